// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write-port arbiter slice:
// arbiter state encoding, register-number geometry and a one-hot helper.
package cpu_pkg;

    localparam int REG_NUM_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HELD  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_t;

    // One-hot select of a register number; r0 never maps to a bit because
    // it is hardwired to zero and must never look busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_NUM_W-1:0] n);
        logic [NUM_REGS-1:0] v;
        v    = NUM_REGS'(1) << n;
        v[0] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Result handshake between the multiply/divide unit and the write-port
// arbiter. The md unit is the master; the arbiter is the slave.
interface regfile_wport_arbiter_if
    import cpu_pkg::*;
#(
    parameter int DW = 32
);

    logic                 md_valid;
    logic [REG_NUM_W-1:0] md_rd;
    logic [DW-1:0]        md_data;
    logic                 md_ready;

    modport master (
        output md_valid,
        output md_rd,
        output md_data,
        input  md_ready
    );

    modport slave (
        input  md_valid,
        input  md_rd,
        input  md_data,
        output md_ready
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for md destinations. A bit is set when ID issues an md op
// and cleared when the md result actually reaches the register file; a set
// and clear of the same register in one cycle leaves it busy, since that is
// a new op targeting the same register. The hazard lookup is combinational.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 set_en,
    input  logic [REG_NUM_W-1:0] set_rd,
    input  logic                 clr_en,
    input  logic [REG_NUM_W-1:0] clr_rd,
    input  logic                 id_valid,
    input  logic [REG_NUM_W-1:0] id_rs,
    input  logic [REG_NUM_W-1:0] id_rt,
    input  logic [REG_NUM_W-1:0] id_rn,
    input  logic                 id_wreg,
    input  logic                 mask_rs,
    input  logic                 mask_rt,
    output logic                 sb_stall
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // Decode this cycle's set and clear requests into one-hot masks.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec = reg_onehot(set_rd);
        if (clr_en) clr_vec = reg_onehot(clr_rd);
    end

    // Busy vector: clear first, then OR in the set so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (clrn) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

    // RAW on either source or WAW on the destination stalls ID.
    always_comb begin
        sb_stall = id_valid & ((busy[id_rs] & ~mask_rs) |
                               (busy[id_rt] & ~mask_rt) |
                               (id_wreg & busy[id_rn]));
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and the
// out-of-band multiply/divide unit. WB always wins the port; an md result
// that collides is parked in a one-entry skid and drained on the next free
// cycle, or forced through with a pipeline stall once it has waited too long.
// Optional macro REGFILE_ARB_BYPASS_EN adds ID operand bypass from md writes.
module regfile_wport_arbiter
    import cpu_pkg::*;
#(
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    wb_wreg,
    input  logic [REG_NUM_W-1:0]    wb_rd,
    input  logic [DW-1:0]           wb_data,
    regfile_wport_arbiter_if.slave  md,
    input  logic                    issue_valid,
    input  logic [REG_NUM_W-1:0]    issue_rd,
    input  logic                    id_valid,
    input  logic [REG_NUM_W-1:0]    id_rs,
    input  logic [REG_NUM_W-1:0]    id_rt,
    input  logic [REG_NUM_W-1:0]    id_rn,
    input  logic                    id_wreg,
    output logic                    rf_we,
    output logic [REG_NUM_W-1:0]    rf_wn,
    output logic [DW-1:0]           rf_d,
    output logic                    sb_stall,
    output logic                    pipe_stall
`ifdef REGFILE_ARB_BYPASS_EN
    ,
    output logic                    byp_a_hit,
    output logic                    byp_b_hit,
    output logic [DW-1:0]           byp_a,
    output logic [DW-1:0]           byp_b
`endif
);

    localparam logic [4:0] FORCE_AT = 5'(STARVE_MAX - 1);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [REG_NUM_W-1:0] skid_rd;
    logic [DW-1:0]        skid_data;
    logic [3:0]           starve_cnt;
    logic                 skid_load;
    logic                 cnt_inc;
    logic                 wr_req;
    logic                 md_write;
    logic                 md_ready_int;
    logic                 force_stall;
    logic                 mask_rs;
    logic                 mask_rt;

    // Port ownership, skid control and next state for the current cycle.
    always_comb begin
        state_next   = state;
        skid_load    = 1'b0;
        cnt_inc      = 1'b0;
        wr_req       = 1'b0;
        md_write     = 1'b0;
        md_ready_int = 1'b0;
        force_stall  = 1'b0;
        rf_wn        = '0;
        rf_d         = '0;
        case (state)
            ARB_IDLE: begin
                md_ready_int = 1'b1;
                if (wb_wreg) begin
                    wr_req = 1'b1;
                    rf_wn  = wb_rd;
                    rf_d   = wb_data;
                    if (md.md_valid) begin
                        skid_load  = 1'b1;
                        state_next = ARB_HELD;
                    end
                end else if (md.md_valid) begin
                    wr_req   = 1'b1;
                    md_write = 1'b1;
                    rf_wn    = md.md_rd;
                    rf_d     = md.md_data;
                end
            end
            ARB_HELD: begin
                if (wb_wreg) begin
                    wr_req  = 1'b1;
                    rf_wn   = wb_rd;
                    rf_d    = wb_data;
                    cnt_inc = 1'b1;
                    if (({1'b0, starve_cnt} + 5'd1) >= FORCE_AT) begin
                        state_next = ARB_FORCE;
                    end
                end else begin
                    wr_req     = 1'b1;
                    md_write   = 1'b1;
                    rf_wn      = skid_rd;
                    rf_d       = skid_data;
                    state_next = ARB_IDLE;
                end
            end
            ARB_FORCE: begin
                wr_req      = 1'b1;
                md_write    = 1'b1;
                force_stall = 1'b1;
                rf_wn       = skid_rd;
                rf_d        = skid_data;
                state_next  = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Writes to r0 are dropped, and nothing leaves the arbiter during reset.
    always_comb begin
        rf_we       = wr_req & (rf_wn != '0) & ~clrn;
        pipe_stall  = force_stall & ~clrn;
        md.md_ready = md_ready_int & ~clrn;
    end

    // State, skid entry and starvation counter; the counter only runs in HELD.
    always_ff @(posedge clk) begin
        if (clrn) begin
            state      <= ARB_IDLE;
            skid_rd    <= '0;
            skid_data  <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (skid_load) begin
                skid_rd   <= md.md_rd;
                skid_data <= md.md_data;
            end
            if (state_next != ARB_HELD) begin
                starve_cnt <= '0;
            end else if (cnt_inc) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef REGFILE_ARB_BYPASS_EN
    // Forward an md result being written this cycle straight to ID operands.
    always_comb begin
        byp_a_hit = md_write & rf_we & (rf_wn == id_rs) & (id_rs != '0);
        byp_b_hit = md_write & rf_we & (rf_wn == id_rt) & (id_rt != '0);
        byp_a     = rf_d;
        byp_b     = rf_d;
        mask_rs   = byp_a_hit;
        mask_rt   = byp_b_hit;
    end
`else
    // Without bypass every busy source must wait for the register file.
    always_comb begin
        mask_rs = 1'b0;
        mask_rt = 1'b0;
    end
`endif

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .clrn     (clrn),
        .set_en   (issue_valid),
        .set_rd   (issue_rd),
        .clr_en   (md_write & ~clrn),
        .clr_rd   (rf_wn),
        .id_valid (id_valid),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rn    (id_rn),
        .id_wreg  (id_wreg),
        .mask_rs  (mask_rs),
        .mask_rt  (mask_rt),
        .sb_stall (sb_stall)
    );

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios followed
// by randomized traffic, all checked against a behavioural model of the
// write-port rules and the busy scoreboard.
// Honours macro REGFILE_ARB_BYPASS_EN when the DUT is built with it.
module tb_regfile_wport_arbiter;

    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int FORCE_AT   = (STARVE_MAX > 1) ? STARVE_MAX - 1 : 1;

    logic          clk;
    logic          clrn;
    logic          wb_wreg;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          id_valid;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [4:0]    id_rn;
    logic          id_wreg;
    logic          rf_we;
    logic [4:0]    rf_wn;
    logic [31:0]   rf_d;
    logic          sb_stall;
    logic          pipe_stall;
`ifdef REGFILE_ARB_BYPASS_EN
    logic          byp_a_hit;
    logic          byp_b_hit;
    logic [31:0]   byp_a;
    logic [31:0]   byp_b;
`endif

    logic          mdv;
    logic [4:0]    mdr;
    logic [31:0]   mdd;

    int            total;
    int            bad;

    bit            m_held;
    logic [4:0]    m_held_rd;
    logic [31:0]   m_held_d;
    int            m_waits;
    bit            m_busy [32];
    bit            m_md_taken;

    regfile_wport_arbiter_if #(.DW(DW)) md_if ();

    assign md_if.md_valid = mdv;
    assign md_if.md_rd    = mdr;
    assign md_if.md_data  = mdd;

    regfile_wport_arbiter #(.DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .wb_wreg     (wb_wreg),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .md          (md_if.slave),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rn       (id_rn),
        .id_wreg     (id_wreg),
        .rf_we       (rf_we),
        .rf_wn       (rf_wn),
        .rf_d        (rf_d),
        .sb_stall    (sb_stall),
        .pipe_stall  (pipe_stall)
`ifdef REGFILE_ARB_BYPASS_EN
        ,
        .byp_a_hit   (byp_a_hit),
        .byp_b_hit   (byp_b_hit),
        .byp_a       (byp_a),
        .byp_b       (byp_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                                 input bit mv, input logic [4:0] mr, input logic [31:0] md_val,
                                 input bit iv, input logic [4:0] ir,
                                 input bit idv, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rn, input bit idw);
        clrn        = rst;
        wb_wreg     = wbw;
        wb_rd       = wbr;
        wb_data     = wbd;
        mdv         = mv;
        mdr         = mr;
        mdd         = md_val;
        issue_valid = iv;
        issue_rd    = ir;
        id_valid    = idv;
        id_rs       = rs;
        id_rt       = rt;
        id_rn       = rn;
        id_wreg     = idw;
    endtask

    task automatic modelReset();
        m_held  = 0;
        m_waits = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
    endtask

    // Compares every output against the model for the current cycle, then
    // advances the model across the coming posedge and waits for the negedge.
    task automatic checkCycle();
        bit          e_wr;
        bit          e_we;
        bit          e_md_src;
        bit          e_ready;
        bit          e_ps;
        bit          e_sb;
        bit          rs_b;
        bit          rt_b;
        bit          rn_b;
        logic [4:0]  e_wn;
        logic [31:0] e_d;
        e_wr       = 0;
        e_md_src   = 0;
        e_ready    = 0;
        e_ps       = 0;
        e_wn       = '0;
        e_d        = '0;
        m_md_taken = 0;
        if (clrn) begin
            checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
            checkOutput("rst_pipe_stall", 32'(pipe_stall), 32'd0);
            modelReset();
            @(negedge clk);
            return;
        end
        if (m_held) begin
            if (m_waits >= FORCE_AT) begin
                e_wr = 1; e_wn = m_held_rd; e_d = m_held_d; e_md_src = 1; e_ps = 1;
            end else if (!wb_wreg) begin
                e_wr = 1; e_wn = m_held_rd; e_d = m_held_d; e_md_src = 1;
            end else begin
                e_wr = 1; e_wn = wb_rd; e_d = wb_data;
            end
        end else begin
            e_ready = 1;
            if (wb_wreg) begin
                e_wr = 1; e_wn = wb_rd; e_d = wb_data;
                if (mdv) m_md_taken = 1;
            end else if (mdv) begin
                e_wr = 1; e_wn = mdr; e_d = mdd; e_md_src = 1; m_md_taken = 1;
            end
        end
        e_we = e_wr && (e_wn != 0);
        rs_b = (id_rs != 0) && m_busy[id_rs];
        rt_b = (id_rt != 0) && m_busy[id_rt];
        rn_b = (id_rn != 0) && m_busy[id_rn];
`ifdef REGFILE_ARB_BYPASS_EN
        begin
            bit hit_a;
            bit hit_b;
            hit_a = e_md_src && e_we && (e_wn == id_rs);
            hit_b = e_md_src && e_we && (e_wn == id_rt);
            checkOutput("byp_a_hit", 32'(byp_a_hit), 32'(hit_a));
            checkOutput("byp_b_hit", 32'(byp_b_hit), 32'(hit_b));
            if (hit_a) checkOutput("byp_a", byp_a, e_d);
            if (hit_b) checkOutput("byp_b", byp_b, e_d);
            if (hit_a) rs_b = 0;
            if (hit_b) rt_b = 0;
        end
`endif
        e_sb = id_valid && (rs_b || rt_b || (id_wreg && rn_b));
        checkOutput("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            checkOutput("rf_wn", 32'(rf_wn), 32'(e_wn));
            checkOutput("rf_d", rf_d, e_d);
        end
        checkOutput("md_ready", 32'(md_if.md_ready), 32'(e_ready));
        checkOutput("pipe_stall", 32'(pipe_stall), 32'(e_ps));
        checkOutput("sb_stall", 32'(sb_stall), 32'(e_sb));
        if (m_held) begin
            if (e_md_src) begin
                m_held  = 0;
                m_waits = 0;
            end else begin
                m_waits++;
            end
        end else if (wb_wreg && mdv) begin
            m_held    = 1;
            m_held_rd = mdr;
            m_held_d  = mdd;
            m_waits   = 0;
        end
        if (e_md_src && e_we) m_busy[e_wn] = 0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
        @(negedge clk);
    endtask

    initial begin
        bit          rst;
        bit          wbw;
        bit          iv;
        bit          idv;
        bit          idw;
        logic [4:0]  wbr;
        logic [4:0]  ir;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rn;
        logic [31:0] wbd;
        total = 0;
        bad   = 0;
        modelReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("[TB] reset");
        #2; checkCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; checkCycle();

        $display("[TB] direct md write when port idle");
        applyStimulus(0, 0, 0, 0, 1, 5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t1_we", 32'(rf_we), 32'd1);
        checkOutput("t1_wn", 32'(rf_wn), 32'd5);
        checkOutput("t1_d", rf_d, 32'hA5A5_A5A5);
        checkOutput("t1_ready", 32'(md_if.md_ready), 32'd1);
        checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t1_still_idle", 32'(md_if.md_ready), 32'd1);
        checkCycle();

        $display("[TB] md collides with WB, drains from skid");
        applyStimulus(0, 1, 3, 32'h3333_3333, 1, 7, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t2_c0_wn", 32'(rf_wn), 32'd3);
        checkOutput("t2_c0_ready", 32'(md_if.md_ready), 32'd1);
        checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t2_c1_wn", 32'(rf_wn), 32'd7);
        checkOutput("t2_c1_d", rf_d, 32'h7777_7777);
        checkOutput("t2_c1_ready", 32'(md_if.md_ready), 32'd0);
        checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t2_c2_ready", 32'(md_if.md_ready), 32'd1);
        checkCycle();

        $display("[TB] starvation forces the skid out");
        applyStimulus(0, 1, 4, 32'h4444_0000, 1, 11, 32'hBBBB_BBBB, 0, 0, 0, 0, 0, 0, 0);
        #2; checkCycle();
        for (int k = 0; k < STARVE_MAX - 1; k++) begin
            applyStimulus(0, 1, 4, 32'h4444_0001 + 32'(k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #2;
            checkOutput("t3_held_wn", 32'(rf_wn), 32'd4);
            checkOutput("t3_held_ps", 32'(pipe_stall), 32'd0);
            checkCycle();
        end
        applyStimulus(0, 1, 4, 32'h4444_00FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t3_force_ps", 32'(pipe_stall), 32'd1);
        checkOutput("t3_force_wn", 32'(rf_wn), 32'd11);
        checkOutput("t3_force_d", rf_d, 32'hBBBB_BBBB);
        checkCycle();
        applyStimulus(0, 1, 4, 32'h4444_00FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t3_resume_wn", 32'(rf_wn), 32'd4);
        checkOutput("t3_resume_ps", 32'(pipe_stall), 32'd0);
        checkCycle();

        $display("[TB] RAW hazard on r9");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        #2; checkCycle();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
            #2;
            checkOutput("t4_raw_wait", 32'(sb_stall), 32'd1);
            checkCycle();
        end
        applyStimulus(0, 0, 0, 0, 1, 9, 32'h9999_0009, 0, 0, 1, 9, 0, 0, 0);
        #2;
`ifdef REGFILE_ARB_BYPASS_EN
        checkOutput("t4_byp_hit", 32'(byp_a_hit), 32'd1);
        checkOutput("t4_byp_a", byp_a, 32'h9999_0009);
        checkOutput("t4_raw_wr", 32'(sb_stall), 32'd0);
`else
        checkOutput("t4_raw_wr", 32'(sb_stall), 32'd1);
`endif
        checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        #2;
        checkOutput("t4_raw_clear", 32'(sb_stall), 32'd0);
        checkCycle();

        $display("[TB] WAW hazard on r9");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        #2; checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 9, 1);
        #2;
        checkOutput("t4_waw_wait", 32'(sb_stall), 32'd1);
        checkCycle();
        applyStimulus(0, 0, 0, 0, 1, 9, 32'h9999_0010, 0, 0, 1, 1, 2, 9, 1);
        #2;
        checkOutput("t4_waw_wr", 32'(sb_stall), 32'd1);
        checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 9, 1);
        #2;
        checkOutput("t4_waw_clear", 32'(sb_stall), 32'd0);
        checkCycle();

        $display("[TB] register zero");
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t5_md_r0", 32'(rf_we), 32'd0);
        checkCycle();
        applyStimulus(0, 1, 0, 32'hDEAD_0001, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t5_wb_r0", 32'(rf_we), 32'd0);
        checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        #2; checkCycle();

        $display("[TB] reset with skid full");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 0);
        #2; checkCycle();
        applyStimulus(0, 1, 5, 32'h5555_5555, 1, 12, 32'hCCCC_CCCC, 0, 0, 0, 0, 0, 0, 0);
        #2; checkCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; checkCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 0);
        #2;
        checkOutput("t6_no_stale", 32'(rf_we), 32'd0);
        checkOutput("t6_idle", 32'(md_if.md_ready), 32'd1);
        checkOutput("t6_busy_clear", 32'(sb_stall), 32'd0);
        checkCycle();

        $display("[TB] randomized traffic");
        mdv = 0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (rst) begin
                mdv = 0;
            end else if (!mdv || m_md_taken) begin
                mdv = ($urandom_range(0, 2) != 0);
                mdr = 5'($urandom_range(0, 7));
                mdd = $urandom;
            end
            wbw = ($urandom_range(0, 3) != 0);
            wbr = 5'($urandom_range(0, 7));
            wbd = $urandom;
            iv  = ($urandom_range(0, 3) == 0);
            ir  = 5'($urandom_range(0, 7));
            idv = ($urandom_range(0, 3) != 0);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rn  = 5'($urandom_range(0, 7));
            idw = ($urandom_range(0, 1) != 0);
            applyStimulus(rst, wbw, wbr, wbd, mdv, mdr, mdd, iv, ir, idv, rs, rt, rn, idw);
            #2; checkCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
